// File: rtl/imem_uart_loader.sv
// UART boot loader: receives an A5 / count / words frame over 8N1 serial and
// writes it into instruction memory, holding the core in reset while loading.
module imem_uart_loader #(
    parameter int unsigned             CLKS_PER_BIT = 868,
    parameter int unsigned             ADDR_W       = 32,
    parameter logic [ADDR_W-1:0]       BASE_ADDR    = '0,
    parameter int unsigned             DEPTH_WORDS  = 256,
    parameter bit                      BOOT_HOLD    = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              uart_rx,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              core_reset,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int unsigned CNT_W    = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned HALF_BIT = CLKS_PER_BIT / 2;
    localparam logic [7:0]  SYNC_BYTE = 8'hA5;

    typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
    typedef enum logic [1:0] {F_SYNC, F_CNT0, F_CNT1, F_DATA} fr_state_t;

    logic              r_rx_s1, r_rx_s2, r_rx_prev;
    rx_state_t         r_rx_state, w_rx_next;
    logic [CNT_W-1:0]  r_cnt;
    logic [2:0]        r_bit_idx;
    logic [7:0]        r_shift;
    logic              r_byte_valid, r_ferr;

    fr_state_t         r_f_state, w_f_next;
    logic [7:0]        r_n_lo;
    logic [15:0]       r_n, r_words;
    logic [1:0]        r_bidx;
    logic [31:0]       r_asm;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic              r_busy, r_done, r_err;
    logic              r_core_reset, r_ever_done, r_release;

    logic              w_rx, w_fall, w_bit_end, w_half;
    logic [15:0]       w_n;
    logic              w_sync_hit, w_abort, w_last_word;

    assign w_rx      = r_rx_s2;
    assign w_fall    = r_rx_prev & ~r_rx_s2;
    assign w_bit_end = (r_cnt == CNT_W'(CLKS_PER_BIT - 1));
    assign w_half    = (r_cnt == CNT_W'(HALF_BIT - 1));

    // Two-flop synchroniser plus previous-sample for falling-edge detection.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rx_s1   <= 1'b1;
            r_rx_s2   <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_rx_s1   <= uart_rx;
            r_rx_s2   <= r_rx_s1;
            r_rx_prev <= r_rx_s2;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) r_rx_state <= R_IDLE;
        else       r_rx_state <= w_rx_next;
    end

    always_comb begin
        w_rx_next = r_rx_state;
        case (r_rx_state)
            R_IDLE:  if (w_fall) w_rx_next = R_START;
            R_START: if (w_half) w_rx_next = w_rx ? R_IDLE : R_DATA;
            R_DATA:  if (w_bit_end && (r_bit_idx == 3'd7)) w_rx_next = R_STOP;
            R_STOP:  if (w_bit_end) w_rx_next = R_IDLE;
            default: w_rx_next = R_IDLE;
        endcase
    end

    // Bit timing and deserialisation; byte_valid / framing error are 1-cycle pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt        <= '0;
            r_bit_idx    <= '0;
            r_shift      <= '0;
            r_byte_valid <= 1'b0;
            r_ferr       <= 1'b0;
        end else begin
            r_byte_valid <= 1'b0;
            r_ferr       <= 1'b0;
            case (r_rx_state)
                R_IDLE: r_cnt <= '0;
                R_START: begin
                    r_bit_idx <= '0;
                    r_cnt     <= w_half ? '0 : r_cnt + CNT_W'(1);
                end
                R_DATA: begin
                    if (w_bit_end) begin
                        r_cnt     <= '0;
                        r_shift   <= {w_rx, r_shift[7:1]};
                        r_bit_idx <= r_bit_idx + 3'd1;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                R_STOP: begin
                    if (w_bit_end) begin
                        r_cnt        <= '0;
                        r_byte_valid <= w_rx;
                        r_ferr       <= ~w_rx;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: r_cnt <= '0;
            endcase
        end
    end

    assign w_n         = {r_shift, r_n_lo};
    assign w_sync_hit  = (r_f_state == F_SYNC) && r_byte_valid && (r_shift == SYNC_BYTE);
    assign w_abort     = (r_f_state != F_SYNC) && r_ferr;
    assign w_last_word = (r_words == (r_n - 16'd1));

    always_ff @(posedge clk) begin
        if (reset) r_f_state <= F_SYNC;
        else       r_f_state <= w_f_next;
    end

    always_comb begin
        w_f_next = r_f_state;
        case (r_f_state)
            F_SYNC: if (w_sync_hit) w_f_next = F_CNT0;
            F_CNT0: begin
                if (w_abort)           w_f_next = F_SYNC;
                else if (r_byte_valid) w_f_next = F_CNT1;
            end
            F_CNT1: begin
                if (w_abort) w_f_next = F_SYNC;
                else if (r_byte_valid)
                    w_f_next = ((w_n == 16'd0) || (32'(w_n) > DEPTH_WORDS)) ? F_SYNC : F_DATA;
            end
            F_DATA: begin
                if (w_abort)                  w_f_next = F_SYNC;
                else if (r_we && w_last_word) w_f_next = F_SYNC;
            end
            default: w_f_next = F_SYNC;
        endcase
    end

    // Frame datapath: count capture, word assembly, write strobe and status flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_n_lo      <= '0;
            r_n         <= '0;
            r_words     <= '0;
            r_bidx      <= '0;
            r_asm       <= '0;
            r_we        <= 1'b0;
            r_addr      <= BASE_ADDR;
            r_wdata     <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_ever_done <= 1'b0;
            r_release   <= 1'b0;
        end else begin
            r_we      <= 1'b0;
            r_release <= 1'b0;
            if (r_we) r_addr <= r_addr + ADDR_W'(4);
            if (w_abort) begin
                r_err     <= 1'b1;
                r_busy    <= 1'b0;
                r_release <= ~BOOT_HOLD | r_ever_done;
            end else begin
                case (r_f_state)
                    F_SYNC: begin
                        if (w_sync_hit) begin
                            r_busy  <= 1'b1;
                            r_err   <= 1'b0;
                            r_done  <= 1'b0;
                            r_addr  <= BASE_ADDR;
                            r_bidx  <= '0;
                            r_words <= '0;
                        end
                    end
                    F_CNT0: if (r_byte_valid) r_n_lo <= r_shift;
                    F_CNT1: begin
                        if (r_byte_valid) begin
                            r_n <= w_n;
                            if (w_n == 16'd0) begin
                                r_done      <= 1'b1;
                                r_busy      <= 1'b0;
                                r_release   <= 1'b1;
                                r_ever_done <= 1'b1;
                            end else if (32'(w_n) > DEPTH_WORDS) begin
                                r_err     <= 1'b1;
                                r_busy    <= 1'b0;
                                r_release <= ~BOOT_HOLD | r_ever_done;
                            end
                        end
                    end
                    F_DATA: begin
                        if (r_byte_valid) begin
                            r_asm  <= {r_shift, r_asm[31:8]};
                            r_bidx <= r_bidx + 2'd1;
                            if (r_bidx == 2'd3) begin
                                r_we    <= 1'b1;
                                r_wdata <= {r_shift, r_asm[31:8]};
                            end
                        end
                        if (r_we) begin
                            r_words <= r_words + 16'd1;
                            if (w_last_word) begin
                                r_done      <= 1'b1;
                                r_busy      <= 1'b0;
                                r_release   <= 1'b1;
                                r_ever_done <= 1'b1;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Core reset: raised at sync detect, dropped one cycle after a frame ends well.
    always_ff @(posedge clk) begin
        if (reset)                     r_core_reset <= 1'b1;
        else if (w_sync_hit)           r_core_reset <= 1'b1;
        else if (r_release)            r_core_reset <= 1'b0;
        else if (!BOOT_HOLD && !r_busy) r_core_reset <= 1'b0;
    end

    assign imem_we    = r_we;
    assign imem_addr  = r_addr;
    assign imem_wdata = r_wdata;
    assign core_reset = r_core_reset;
    assign busy       = r_busy;
    assign done       = r_done;
    assign err        = r_err;

endmodule

// File: tb/tb_imem_uart_loader.sv
// Directed bench for imem_uart_loader: table of serial frames with expected
// writes and final status, plus hand-written reset-state and mid-frame reset cases.
module tb_imem_uart_loader;

    localparam int unsigned CPB = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        uart_rx;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        core_reset, busy, done, err;

    imem_uart_loader #(
        .CLKS_PER_BIT(CPB), .ADDR_W(32), .BASE_ADDR(32'h0),
        .DEPTH_WORDS(8), .BOOT_HOLD(1'b1)
    ) dut (
        .clk(clk), .reset(reset), .uart_rx(uart_rx),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .core_reset(core_reset), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Write capture, strobe-width tracking and core_reset release after done rises.
    logic [31:0] wr_a[$];
    logic [31:0] wr_d[$];
    int   long_cnt = 0;
    logic we_prev = 1'b0;
    logic done_prev = 1'b0;
    bit   cr_pending = 1'b0;

    always begin
        @(posedge clk);
        #1;
        if (imem_we === 1'b1) begin
            wr_a.push_back(imem_addr);
            wr_d.push_back(imem_wdata);
            if (we_prev) long_cnt++;
        end
        we_prev = (imem_we === 1'b1);
        if (cr_pending) begin
            chk("core_reset_falls_after_done", {31'b0, core_reset}, 32'd0);
            cr_pending = 1'b0;
        end
        if (done === 1'b1 && !done_prev && reset === 1'b0) begin
            chk("core_reset_high_at_done", {31'b0, core_reset}, 32'd1);
            cr_pending = 1'b1;
        end
        done_prev = (done === 1'b1);
    end

    task automatic send_bit(input logic v);
        uart_rx = v;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_ok);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(stop_ok);
        send_bit(1'b1);
        send_bit(1'b1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        uart_rx = 1'b1;
        reset   = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic sample();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic              rst;
        logic              glitch;
        int                nb;
        logic [0:11][7:0]  b;
        int                bad;
        int                nw;
        logic [0:1][31:0]  wa;
        logic [0:1][31:0]  wd;
        logic              e_done;
        logic              e_err;
        logic              e_cr;
    } vec_t;

    function automatic vec_t mkv(input logic rst, input logic glitch, input int nb,
                                 input logic [0:11][7:0] b, input int bad, input int nw,
                                 input logic [0:1][31:0] wa, input logic [0:1][31:0] wd,
                                 input logic e_done, input logic e_err, input logic e_cr);
        vec_t v;
        v.rst = rst; v.glitch = glitch; v.nb = nb; v.b = b; v.bad = bad; v.nw = nw;
        v.wa = wa; v.wd = wd; v.e_done = e_done; v.e_err = e_err; v.e_cr = e_cr;
        return v;
    endfunction

    vec_t vecs[8];

    initial begin
        vecs[0] = mkv(1, 0, 11, {8'hA5, 8'h02, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00,
                                 8'h93, 8'h05, 8'h20, 8'h00, 8'h00},
                      -1, 2, {32'h0, 32'h4}, {32'h0010_0513, 32'h0020_0593}, 1, 0, 0);
        vecs[1] = mkv(1, 0, 3, {8'hA5, 8'h09, 8'h00, 72'h0}, -1, 0, '0, '0, 0, 1, 1);
        vecs[2] = mkv(0, 0, 5, {8'hA5, 8'h01, 8'h00, 8'hEF, 8'h55, 56'h0}, 4, 0, '0, '0, 0, 1, 1);
        vecs[3] = mkv(0, 0, 7, {8'hA5, 8'h01, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 40'h0},
                      -1, 1, {32'h0, 32'h0}, {32'h0000_0013, 32'h0}, 1, 0, 0);
        vecs[4] = mkv(1, 1, 5, {8'h3C, 8'h7F, 8'hA5, 8'h00, 8'h00, 56'h0}, -1, 0, '0, '0, 1, 0, 0);
        vecs[5] = mkv(1, 0, 7, {8'hA5, 8'h01, 8'h00, 8'hA5, 8'hA5, 8'h00, 8'h00, 40'h0},
                      -1, 1, {32'h0, 32'h0}, {32'h0000_A5A5, 32'h0}, 1, 0, 0);
        vecs[6] = mkv(1, 0, 4, {8'h11, 8'hA5, 8'h00, 8'h00, 64'h0}, 0, 0, '0, '0, 1, 0, 0);
        vecs[7] = mkv(0, 0, 3, {8'hA5, 8'h09, 8'h00, 72'h0}, -1, 0, '0, '0, 0, 1, 0);

        uart_rx = 1'b1;
        reset   = 1'b1;
        repeat (4) @(negedge clk);

        // Reset state and a quiet line.
        do_reset();
        wr_a.delete(); wr_d.delete();
        repeat (100) @(negedge clk);
        sample();
        chk("idle_writes", 32'(wr_a.size()), 32'd0);
        chk("idle_core_reset", {31'b0, core_reset}, 32'd1);
        chk("idle_busy", {31'b0, busy}, 32'd0);
        chk("idle_done", {31'b0, done}, 32'd0);
        chk("idle_err", {31'b0, err}, 32'd0);
        chk("idle_addr", imem_addr, 32'h0);
        chk("idle_wdata", imem_wdata, 32'h0);

        for (int i = 0; i < 8; i++) begin
            if (vecs[i].rst) do_reset();
            @(negedge clk);
            wr_a.delete(); wr_d.delete();
            if (vecs[i].glitch) begin
                uart_rx = 1'b0;
                @(negedge clk);
                uart_rx = 1'b1;
                repeat (12) @(negedge clk);
            end
            for (int j = 0; j < vecs[i].nb; j++)
                send_byte(vecs[i].b[j], (j != vecs[i].bad));
            repeat (60) @(negedge clk);
            sample();
            chk($sformatf("v%0d_nwrites", i), 32'(wr_a.size()), 32'(vecs[i].nw));
            for (int w = 0; w < vecs[i].nw; w++) begin
                chk($sformatf("v%0d_w%0d_addr", i, w),
                    (w < wr_a.size()) ? wr_a[w] : 32'hDEAD_BEEF, vecs[i].wa[w]);
                chk($sformatf("v%0d_w%0d_data", i, w),
                    (w < wr_d.size()) ? wr_d[w] : 32'hDEAD_BEEF, vecs[i].wd[w]);
            end
            chk($sformatf("v%0d_done", i), {31'b0, done}, {31'b0, vecs[i].e_done});
            chk($sformatf("v%0d_err", i), {31'b0, err}, {31'b0, vecs[i].e_err});
            chk($sformatf("v%0d_busy", i), {31'b0, busy}, 32'd0);
            chk($sformatf("v%0d_core_reset", i), {31'b0, core_reset}, {31'b0, vecs[i].e_cr});
        end

        // Reset in the middle of a 1-word frame, then a clean reload.
        do_reset();
        @(negedge clk);
        wr_a.delete(); wr_d.delete();
        send_byte(8'hA5, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'hAA, 1'b1);
        send_byte(8'hBB, 1'b1);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        sample();
        chk("midrst_we", {31'b0, imem_we}, 32'd0);
        chk("midrst_addr", imem_addr, 32'h0);
        chk("midrst_wdata", imem_wdata, 32'h0);
        chk("midrst_busy", {31'b0, busy}, 32'd0);
        chk("midrst_done", {31'b0, done}, 32'd0);
        chk("midrst_err", {31'b0, err}, 32'd0);
        chk("midrst_core_reset", {31'b0, core_reset}, 32'd1);
        @(negedge clk);
        reset = 1'b0;
        repeat (20) @(negedge clk);
        chk("midrst_nwrites", 32'(wr_a.size()), 32'd0);
        foreach (vecs[0].b[k]) ;
        send_byte(8'hA5, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h78, 1'b1);
        send_byte(8'h56, 1'b1);
        send_byte(8'h34, 1'b1);
        send_byte(8'h12, 1'b1);
        repeat (60) @(negedge clk);
        sample();
        chk("reload_nwrites", 32'(wr_a.size()), 32'd1);
        chk("reload_addr", (wr_a.size() > 0) ? wr_a[0] : 32'hDEAD_BEEF, 32'h0);
        chk("reload_data", (wr_d.size() > 0) ? wr_d[0] : 32'hDEAD_BEEF, 32'h1234_5678);
        chk("reload_done", {31'b0, done}, 32'd1);
        chk("reload_core_reset", {31'b0, core_reset}, 32'd0);

        chk("strobe_single_cycle", 32'(long_cnt), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
